// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART Tx core: launches one frame at a time with a
// Data_Valid strobe and pops the head only once the core raises busy.
// Optional busy-rise timeout is enabled by defining TX_FEEDER_TIMEOUT_EN.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int BUSY_TO    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    busy,
  output logic                    Data_Valid,
  output logic [DATA_WIDTH-1:0]   P_DATA,
  output logic                    to_err,
  output logic [1:0]              state_dbg_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BUSY_TO < 2) begin : g_param_check
    $error("uart_tx_feeder: DEPTH must be a power of 2 >= 2 and BUSY_TO >= 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   push, pop, timeout;

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = wr_en && full;
  assign push     = wr_en && !full;
  // Commit-on-ack: the head leaves the FIFO only when the core raises busy.
  assign pop      = (state_q == WAIT_BUSY) && busy && !empty;
  assign P_DATA   = empty ? '0 : mem_q[rd_ptr_q];
  assign Data_Valid  = (state_q == LAUNCH);
  assign state_dbg_o = state_q;

`ifdef TX_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TO) + 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counter is zero on entry to WAIT_BUSY; fires on the BUSY_TO-th cycle there.
  assign timeout = (state_q == WAIT_BUSY) && !busy && (to_cnt_q == TW'(BUSY_TO - 1));
  assign to_err  = timeout;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT_BUSY) to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
  assign to_err  = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake: Data_Valid pulses for one cycle only from IDLE with busy low;
  // busy rising acknowledges the frame, busy falling ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && !busy) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy)         state_d = WAIT_DONE;
        else if (timeout) state_d = IDLE;
      end
      WAIT_DONE: if (!busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: behavioural Tx-core busy model,
// FIFO scoreboard, table-driven bursts and hand-written corner sequences.
module tb_uart_tx_feeder;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int BUSY_TO = 8;
  localparam int FRAME   = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT_BUSY = 2'd2, S_WAIT_DONE = 2'd3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, busy, Data_Valid, to_err;
  logic [4:0]    count;
  logic [DW-1:0] P_DATA;
  logic [1:0]    state_dbg;

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .to_err(to_err), .state_dbg_o(state_dbg)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  int n_strobe = 0, n_ovf = 0, n_toerr = 0, cyc = 0;
  int first_dv_cyc = -1, first_to_cyc = -1;
  bit awaiting = 0;
  int busy_mode = 0;  // 0: core model, 1: busy held high, 2: busy stuck low
  int rem = 0;
  logic busy_nx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rst);
    logic room;
    logic [DW-1:0] exp_head;
    wr_en = wr; wr_data = d; RST = rst;
    #1;
    room     = (exp_q.size() < DEPTH);
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("count",    32'(count),    32'(exp_q.size()));
    chk("full",     32'(full),     32'(!room));
    chk("empty",    32'(empty),    32'(exp_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(wr && !room));
    chk("p_data",   32'(P_DATA),   32'(exp_head));
    if (Data_Valid) begin
      chk("dv_while_busy", 32'(busy), 32'(0));
      n_strobe++;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
    end
    if (overflow) n_ovf++;
    if (to_err) begin
      n_toerr++;
      if (first_to_cyc < 0) first_to_cyc = cyc;
    end
    if (!rst) begin
      exp_q.delete();
      awaiting = 0;
    end else begin
      if (awaiting && busy) begin
        void'(exp_q.pop_front());
        awaiting = 0;
      end
      if (to_err) awaiting = 0;
      if (Data_Valid) awaiting = 1;
      if (wr && room) exp_q.push_back(d);
    end
    if (busy_mode == 1)      busy_nx = 1'b1;
    else if (busy_mode == 2) busy_nx = 1'b0;
    else begin
      if (Data_Valid) rem = FRAME;
      if (rem > 0) begin busy_nx = 1'b1; rem--; end
      else busy_nx = 1'b0;
    end
    @(posedge CLK); #1;
    busy = busy_nx;
    cyc++;
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while ((exp_q.size() != 0 || rem != 0 || busy) && i < bound) begin
      cycle(1'b0, '0, 1'b1);
      i++;
    end
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("drain_in_budget", 32'(i < bound), 32'(1));
  endtask

  typedef struct {
    int          n;
    int          gap;
    bit          rnd;
    logic [7:0]  base;
    logic [7:0]  step;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s0, o0, t0, wcyc, i;
    bit found;
    logic [DW-1:0] d;

    vecs[0] = '{3,  0, 1'b0, 8'h11, 8'h11, 3};
    vecs[1] = '{5,  2, 1'b1, 8'h00, 8'h00, 5};
    vecs[2] = '{17, 0, 1'b0, 8'hC0, 8'h01, 17};
    vecs[3] = '{4,  9, 1'b0, 8'h80, 8'h07, 4};

    RST = 1'b0; wr_en = 1'b0; wr_data = '0; busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_empty",   32'(empty),      32'(1));
    chk("rst_full",    32'(full),       32'(0));
    chk("rst_count",   32'(count),      32'(0));
    chk("rst_dv",      32'(Data_Valid), 32'(0));
    chk("rst_pdata",   32'(P_DATA),     32'(0));
    chk("rst_ovf",     32'(overflow),   32'(0));
    chk("rst_to_err",  32'(to_err),     32'(0));
    chk("rst_state",   32'(state_dbg),  32'(S_IDLE));

    // single byte: strobe two cycles after the write
    s0 = n_strobe; first_dv_cyc = -1; wcyc = cyc;
    cycle(1'b1, 8'hA5, 1'b1);
    drain(100);
    chk("t1_latency", 32'(first_dv_cyc - wcyc), 32'(2));
    chk("t1_strobes", 32'(n_strobe - s0), 32'(1));

    // table-driven bursts
    foreach (vecs[v]) begin
      s0 = n_strobe;
      for (int k = 0; k < vecs[v].n; k++) begin
        d = vecs[v].rnd ? DW'($urandom_range(0, 255)) : DW'(vecs[v].base + 8'(k) * vecs[v].step);
        cycle(1'b1, d, 1'b1);
        repeat (vecs[v].gap) cycle(1'b0, '0, 1'b1);
      end
      drain(400);
      chk($sformatf("vec%0d_strobes", v), 32'(n_strobe - s0), 32'(vecs[v].exp_strobes));
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(0));
    end

    // fill while core busy, then one write too many
    busy_mode = 1;
    cycle(1'b0, '0, 1'b1);
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, DW'(8'h40 + k), 1'b1);
    o0 = n_ovf;
    cycle(1'b1, 8'hFF, 1'b1);
    chk("t3_ovf_pulses", 32'(n_ovf - o0), 32'(1));
    chk("t3_full",       32'(full),       32'(1));
    chk("t3_count",      32'(count),      32'(DEPTH));

    // write coinciding with the pop cycle while full is dropped
    busy_mode = 0; s0 = n_strobe; found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (n_strobe != s0) found = 1;
    end
    chk("t4_launch_seen", 32'(found), 32'(1));
    o0 = n_ovf;
    cycle(1'b1, 8'hEE, 1'b1);
    chk("t4_ovf_pulses", 32'(n_ovf - o0), 32'(1));
    chk("t4_count",      32'(count),      32'(DEPTH - 1));
    drain(400);
    chk("t4_strobes", 32'(n_strobe - s0), 32'(DEPTH));

    // reset during WAIT_DONE with four bytes queued
    for (int k = 0; k < 5; k++) cycle(1'b1, DW'(8'h60 + k), 1'b1);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (state_dbg == S_WAIT_DONE && count == 5'd4) found = 1;
      else cycle(1'b0, '0, 1'b1);
    end
    chk("t5_wait_done_seen", 32'(found), 32'(1));
    cycle(1'b0, '0, 1'b0);
    rem = 0; busy = 1'b0;
    chk("t5_empty", 32'(empty),      32'(1));
    chk("t5_dv",    32'(Data_Valid), 32'(0));
    chk("t5_state", 32'(state_dbg),  32'(S_IDLE));
    s0 = n_strobe;
    repeat (10) cycle(1'b0, '0, 1'b1);
    chk("t5_no_strobe", 32'(n_strobe - s0), 32'(0));
    cycle(1'b1, 8'h3C, 1'b1);
    drain(100);
    chk("t5_new_strobe", 32'(n_strobe - s0), 32'(1));

    // busy never rises
    busy_mode = 2; s0 = n_strobe; t0 = n_toerr;
    first_dv_cyc = -1; first_to_cyc = -1;
`ifdef TX_FEEDER_TIMEOUT_EN
    cycle(1'b1, 8'h5A, 1'b1);
    i = 0;
    while (n_toerr - t0 < 2 && i < 60) begin
      cycle(1'b0, '0, 1'b1);
      i++;
    end
    chk("t6_timeouts_seen", 32'(n_toerr - t0), 32'(2));
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("t6_to_delay", 32'(first_to_cyc - first_dv_cyc), 32'(BUSY_TO));
    chk("t6_strobes",  32'(n_strobe - s0), 32'(3));
    chk("t6_count",    32'(count), 32'(1));
    busy_mode = 0;
    drain(100);
    chk("t6_final_count", 32'(count), 32'(0));
`else
    cycle(1'b1, 8'h5A, 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b1);
    chk("t6_strobes", 32'(n_strobe - s0), 32'(1));
    chk("t6_to_err",  32'(n_toerr - t0),  32'(0));
    chk("t6_count",   32'(count),         32'(1));
    chk("t6_state",   32'(state_dbg),     32'(S_WAIT_BUSY));
    cycle(1'b0, '0, 1'b0);
    busy_mode = 0; rem = 0; busy = 1'b0;
    chk("t6_reset_empty", 32'(empty), 32'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
